// File: rtl/uart_rx_core.sv
// UART receiver: 2-flop synchronized rx, programmable baud-tick oversampling,
// start/parity/stop checking, and a valid/ready byte output with error flags.
module uart_rx_core #(
    parameter int DATA_WIDTH = 8,
    parameter int OVERSAMPLE = 16,
    parameter int DIV_WIDTH  = 16
) (
    input  logic                  pclk,
    input  logic                  areset,
    input  logic [DIV_WIDTH-1:0]  baud_div,
    input  logic                  parity_en,
    input  logic                  parity_odd,
    input  logic                  stop_bits_2,
    input  logic                  rx,
    output logic [DATA_WIDTH-1:0] rx_data,
    output logic                  rx_valid,
    input  logic                  rx_ready,
    output logic                  parity_err,
    output logic                  frame_err,
    output logic                  overrun_err,
    output logic                  busy
);

    // Handshake: a byte transfers on every pclk edge where rx_valid && rx_ready;
    // rx_data and the error flags are held constant while rx_valid is high.

    localparam int SC_W = $clog2(OVERSAMPLE);
    localparam int BI_W = $clog2(DATA_WIDTH);
    localparam logic [SC_W-1:0] MID_START = SC_W'(OVERSAMPLE / 2 - 1);
    localparam logic [SC_W-1:0] MID_BIT   = SC_W'(OVERSAMPLE - 1);
    localparam logic [BI_W-1:0] LAST_BIT  = BI_W'(DATA_WIDTH - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP1,
        S_STOP2
    } state_t;

    state_t                 state;
    logic                   rx_meta;
    logic                   rx_s;
    logic                   rx_prev;
    logic                   start_det;
    logic [DIV_WIDTH-1:0]   div_eff;
    logic [DIV_WIDTH-1:0]   tick_cnt;
    logic                   tick;
    logic [SC_W-1:0]        sc;
    logic                   mid;
    logic [BI_W-1:0]        bit_idx;
    logic [DATA_WIDTH-1:0]  shreg;
    logic                   cfg_par;
    logic                   cfg_odd;
    logic                   cfg_stop2;
    logic                   par_bad;
    logic                   stop1_bad;
    logic                   complete;
    logic                   frame_bad;
    logic                   load_ok;

    always_ff @(posedge pclk or negedge areset) begin
        if (!areset) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_s    <= rx_meta;
            rx_prev <= rx_s;
        end
    end

    // Edges are only looked for while idle; activity mid-frame is ignored.
    assign start_det = (state == S_IDLE) && rx_prev && !rx_s;

    assign div_eff = (baud_div == '0) ? DIV_WIDTH'(1) : baud_div;
    // >= keeps the counter from running the long way round if baud_div shrinks.
    assign tick    = (tick_cnt >= div_eff - DIV_WIDTH'(1));

    always_ff @(posedge pclk or negedge areset) begin
        if (!areset) begin
            tick_cnt <= '0;
        end else if (start_det || tick) begin
            tick_cnt <= '0;
        end else begin
            tick_cnt <= tick_cnt + DIV_WIDTH'(1);
        end
    end

    assign mid = tick && (sc == ((state == S_START) ? MID_START : MID_BIT));

    always_comb begin
        complete  = 1'b0;
        frame_bad = 1'b0;
        if (mid) begin
            case (state)
                S_STOP1: begin
                    if (!cfg_stop2) begin
                        complete  = 1'b1;
                        frame_bad = !rx_s;
                    end
                end
                S_STOP2: begin
                    complete  = 1'b1;
                    frame_bad = stop1_bad || !rx_s;
                end
                default: begin
                    complete  = 1'b0;
                    frame_bad = 1'b0;
                end
            endcase
        end
    end

    assign load_ok = !rx_valid || rx_ready;

    always_ff @(posedge pclk or negedge areset) begin
        if (!areset) begin
            state       <= S_IDLE;
            sc          <= '0;
            bit_idx     <= '0;
            shreg       <= '0;
            cfg_par     <= 1'b0;
            cfg_odd     <= 1'b0;
            cfg_stop2   <= 1'b0;
            par_bad     <= 1'b0;
            stop1_bad   <= 1'b0;
            rx_data     <= '0;
            rx_valid    <= 1'b0;
            parity_err  <= 1'b0;
            frame_err   <= 1'b0;
            overrun_err <= 1'b0;
            busy        <= 1'b0;
        end else begin
            overrun_err <= 1'b0;
            if (rx_valid && rx_ready) begin
                rx_valid <= 1'b0;
            end
            // A fresh load in the same cycle as an accept keeps rx_valid high.
            if (complete) begin
                if (load_ok) begin
                    rx_data    <= shreg;
                    rx_valid   <= 1'b1;
                    parity_err <= par_bad;
                    frame_err  <= frame_bad;
                end else begin
                    overrun_err <= 1'b1;
                end
            end

            if (tick) begin
                sc <= sc + SC_W'(1);
            end

            case (state)
                S_IDLE: begin
                    sc <= '0;
                    if (start_det) begin
                        state     <= S_START;
                        busy      <= 1'b1;
                        cfg_par   <= parity_en;
                        cfg_odd   <= parity_odd;
                        cfg_stop2 <= stop_bits_2;
                        par_bad   <= 1'b0;
                        stop1_bad <= 1'b0;
                    end
                end
                S_START: begin
                    if (mid) begin
                        sc <= '0;
                        if (rx_s) begin
                            state <= S_IDLE;
                            busy  <= 1'b0;
                        end else begin
                            state   <= S_DATA;
                            bit_idx <= '0;
                        end
                    end
                end
                S_DATA: begin
                    if (mid) begin
                        sc    <= '0;
                        shreg <= {rx_s, shreg[DATA_WIDTH-1:1]};
                        if (bit_idx == LAST_BIT) begin
                            state <= cfg_par ? S_PARITY : S_STOP1;
                        end else begin
                            bit_idx <= bit_idx + BI_W'(1);
                        end
                    end
                end
                S_PARITY: begin
                    if (mid) begin
                        sc      <= '0;
                        par_bad <= (^shreg) ^ rx_s ^ cfg_odd;
                        state   <= S_STOP1;
                    end
                end
                S_STOP1: begin
                    if (mid) begin
                        sc        <= '0;
                        stop1_bad <= !rx_s;
                        if (cfg_stop2) begin
                            state <= S_STOP2;
                        end else begin
                            state <= S_IDLE;
                            busy  <= 1'b0;
                        end
                    end
                end
                S_STOP2: begin
                    if (mid) begin
                        sc    <= '0;
                        state <= S_IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx_core.sv
// Bench for uart_rx_core: vector table, randomized frames against a frame-level
// model, and hand-written break, glitch, overrun and reset sequences.
module tb_uart_rx_core;

    localparam int OS = 16;

    logic        pclk;
    logic        areset;
    logic [15:0] baud_div;
    logic        parity_en;
    logic        parity_odd;
    logic        stop_bits_2;
    logic        rx;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic        parity_err;
    logic        frame_err;
    logic        overrun_err;
    logic        busy;

    int n_cmp = 0;
    int n_bad = 0;
    int ovr_cnt = 0;
    bit mon_en = 0;
    bit rand_ready = 0;
    bit ready_hold = 0;
    logic [9:0] exp_q[$];

    typedef struct {
        logic [7:0] data;
        bit         pen;
        bit         podd;
        bit         s2;
        bit         pbit;
        bit         st1;
        bit         st2;
        logic [7:0] e_data;
        bit         e_perr;
        bit         e_ferr;
    } vec_t;

    vec_t vecs[11];

    uart_rx_core #(.DATA_WIDTH(8), .OVERSAMPLE(OS), .DIV_WIDTH(16)) dut (
        .pclk        (pclk),
        .areset      (areset),
        .baud_div    (baud_div),
        .parity_en   (parity_en),
        .parity_odd  (parity_odd),
        .stop_bits_2 (stop_bits_2),
        .rx          (rx),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .rx_ready    (rx_ready),
        .parity_err  (parity_err),
        .frame_err   (frame_err),
        .overrun_err (overrun_err),
        .busy        (busy)
    );

    // Clock and reset-free background processes.
    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    always @(posedge pclk) begin
        #2;
        rx_ready = rand_ready ? 1'($urandom_range(0, 1)) : ready_hold;
    end

    always @(negedge pclk) if (overrun_err) ovr_cnt++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Scoreboard: every accepted byte is matched against the oldest expectation.
    always @(negedge pclk) begin
        if (mon_en && areset && rx_valid && rx_ready) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_byte: got %0h expected none", {frame_err, parity_err, rx_data});
            end else begin
                check("rand_byte", {22'd0, frame_err, parity_err, rx_data}, {22'd0, exp_q.pop_front()});
            end
        end
    end

    // Driver tasks: all start and end 1 time unit after a rising edge.
    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge pclk);
            #1;
        end
    endtask

    task automatic send_frame(input logic [7:0] d, input bit pen, input bit pbit, input bit st1,
                              input bit s2, input bit st2, input int div, input int gap,
                              input bit scramble);
        int bp;
        bp = OS * ((div < 1) ? 1 : div);
        rx = 1'b0;
        cyc(bp);
        // Config is latched at the start edge, so mid-frame changes must not matter.
        if (scramble) begin
            parity_en   = 1'($urandom_range(0, 1));
            parity_odd  = 1'($urandom_range(0, 1));
            stop_bits_2 = 1'($urandom_range(0, 1));
        end
        for (int i = 0; i < 8; i++) begin
            rx = d[i];
            cyc(bp);
        end
        if (pen) begin
            rx = pbit;
            cyc(bp);
        end
        rx = st1;
        cyc(bp);
        if (s2) begin
            rx = st2;
            cyc(bp);
        end
        rx = 1'b1;
        cyc(gap);
    endtask

    task automatic wait_valid(input int budget, output int n, output bit ok);
        n = 0;
        while (!rx_valid && n < budget) begin
            @(negedge pclk);
            n++;
        end
        ok = rx_valid;
    endtask

    task automatic accept_byte(input string tag);
        cyc(1);
        ready_hold = 1'b1;
        cyc(1);
        check({tag, "_valid_fall"}, {31'd0, rx_valid}, 32'd0);
        ready_hold = 1'b0;
    endtask

    function automatic logic [9:0] model(input logic [7:0] d, input bit pen, input bit podd,
                                         input bit pbit, input bit st1, input bit s2, input bit st2);
        bit perr;
        bit ferr;
        perr = pen && ((($countones(d) + int'(pbit)) % 2) != (podd ? 1 : 0));
        ferr = !st1 || (s2 && !st2);
        return {ferr, perr, d};
    endfunction

    task automatic set_cfg(input bit pen, input bit podd, input bit s2, input logic [15:0] div);
        parity_en   = pen;
        parity_odd  = podd;
        stop_bits_2 = s2;
        baud_div    = div;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_data"}, {24'd0, rx_data}, 32'd0);
        check({tag, "_valid"}, {31'd0, rx_valid}, 32'd0);
        check({tag, "_perr"}, {31'd0, parity_err}, 32'd0);
        check({tag, "_ferr"}, {31'd0, frame_err}, 32'd0);
        check({tag, "_ovr"}, {31'd0, overrun_err}, 32'd0);
        check({tag, "_busy"}, {31'd0, busy}, 32'd0);
    endtask

    initial begin
        int         n;
        bit         ok;
        int         nv;
        logic [9:0] cap;
        logic [7:0] d;
        bit         pen, podd, s2, pbit, st1, st2;
        int         div;

        vecs[0]  = '{8'hA5, 0, 0, 0, 0, 1, 1, 8'hA5, 0, 0};
        vecs[1]  = '{8'h3C, 1, 0, 0, 1, 1, 1, 8'h3C, 1, 0};
        vecs[2]  = '{8'h3C, 1, 0, 0, 0, 1, 1, 8'h3C, 0, 0};
        vecs[3]  = '{8'h3C, 1, 1, 0, 1, 1, 1, 8'h3C, 0, 0};
        vecs[4]  = '{8'h3C, 1, 1, 0, 0, 1, 1, 8'h3C, 1, 0};
        vecs[5]  = '{8'h81, 0, 0, 1, 0, 1, 0, 8'h81, 0, 1};
        vecs[6]  = '{8'h81, 0, 0, 1, 0, 0, 1, 8'h81, 0, 1};
        vecs[7]  = '{8'h00, 0, 0, 0, 0, 0, 1, 8'h00, 0, 1};
        vecs[8]  = '{8'hFF, 1, 0, 0, 0, 1, 1, 8'hFF, 0, 0};
        vecs[9]  = '{8'h7E, 1, 1, 1, 1, 1, 1, 8'h7E, 0, 0};
        vecs[10] = '{8'h01, 1, 0, 1, 0, 1, 0, 8'h01, 1, 1};

        areset = 1'b0;
        rx     = 1'b1;
        set_cfg(0, 0, 0, 16'd1);
        cyc(5);
        check_reset_outputs("reset");
        areset = 1'b1;
        cyc(5);

        // Clean 8N1 0xA5 with latency measured from the start edge.
        fork
            send_frame(8'hA5, 0, 0, 1, 0, 1, 1, 8, 0);
            wait_valid(400, n, ok);
        join
        check("clean_valid", {31'd0, ok}, 32'd1);
        n_cmp++;
        if (n < 150 || n > 158) begin
            n_bad++;
            $display("FAIL clean_latency: got %0d cycles expected 150..158", n);
        end
        check("clean_data", {24'd0, rx_data}, 32'hA5);
        check("clean_perr", {31'd0, parity_err}, 32'd0);
        check("clean_ferr", {31'd0, frame_err}, 32'd0);
        accept_byte("clean");

        // Vector table.
        for (int i = 0; i < 11; i++) begin
            set_cfg(vecs[i].pen, vecs[i].podd, vecs[i].s2, 16'd1);
            send_frame(vecs[i].data, vecs[i].pen, vecs[i].pbit, vecs[i].st1, vecs[i].s2,
                       vecs[i].st2, 1, 8, 0);
            wait_valid(400, n, ok);
            check($sformatf("vec%0d_valid", i), {31'd0, ok}, 32'd1);
            check($sformatf("vec%0d_data", i), {24'd0, rx_data}, {24'd0, vecs[i].e_data});
            check($sformatf("vec%0d_perr", i), {31'd0, parity_err}, {31'd0, vecs[i].e_perr});
            check($sformatf("vec%0d_ferr", i), {31'd0, frame_err}, {31'd0, vecs[i].e_ferr});
            accept_byte($sformatf("vec%0d", i));
        end

        // Held-low line: exactly one 0x00 frame_err byte, then silence.
        set_cfg(0, 0, 0, 16'd1);
        ready_hold = 1'b1;
        cyc(2);
        rx = 1'b0;
        nv = 0;
        cap = '0;
        for (int i = 0; i < 700; i++) begin
            cyc(1);
            if (rx_valid) begin
                nv++;
                cap = {frame_err, parity_err, rx_data};
            end
        end
        check("break_count", nv, 32'd1);
        check("break_byte", {22'd0, cap}, {22'd0, 10'h200});
        ready_hold = 1'b0;
        rx = 1'b1;
        cyc(10);
        send_frame(8'h81, 0, 0, 1, 0, 1, 1, 8, 0);
        wait_valid(400, n, ok);
        check("after_break_valid", {31'd0, ok}, 32'd1);
        check("after_break_data", {22'd0, frame_err, parity_err, rx_data}, 32'h081);
        accept_byte("after_break");

        // Glitch shorter than half a bit.
        rx = 1'b0;
        cyc(4);
        check("glitch_busy_hi", {31'd0, busy}, 32'd1);
        rx = 1'b1;
        nv = 0;
        for (int i = 0; i < 40; i++) begin
            cyc(1);
            if (rx_valid) nv++;
        end
        check("glitch_no_valid", nv, 32'd0);
        check("glitch_busy_lo", {31'd0, busy}, 32'd0);

        // Overrun: second frame dropped while the first is still held.
        ovr_cnt = 0;
        send_frame(8'h11, 0, 0, 1, 0, 1, 1, 8, 0);
        send_frame(8'h22, 0, 0, 1, 0, 1, 1, 8, 0);
        check("ovr_data", {24'd0, rx_data}, 32'h11);
        check("ovr_valid", {31'd0, rx_valid}, 32'd1);
        check("ovr_pulse_cycles", ovr_cnt, 32'd1);
        accept_byte("ovr_drain");
        send_frame(8'h33, 0, 0, 1, 0, 1, 1, 8, 0);
        wait_valid(400, n, ok);
        check("ovr_next_valid", {31'd0, ok}, 32'd1);
        check("ovr_next_data", {24'd0, rx_data}, 32'h33);
        check("ovr_no_more_pulses", ovr_cnt, 32'd1);
        accept_byte("ovr_next");

        // Reset during data bit 3 with a byte already held.
        send_frame(8'h44, 0, 0, 1, 0, 1, 1, 8, 0);
        rx = 1'b0;
        cyc(OS);
        for (int i = 0; i < 3; i++) begin
            rx = i[0];
            cyc(OS);
        end
        rx = 1'b1;
        cyc(OS / 2);
        check("midrst_pre_busy", {31'd0, busy}, 32'd1);
        check("midrst_pre_valid", {31'd0, rx_valid}, 32'd1);
        areset = 1'b0;
        #1;
        check_reset_outputs("midrst");
        cyc(3);
        rx = 1'b1;
        areset = 1'b1;
        cyc(5);
        set_cfg(0, 0, 0, 16'd3);
        send_frame(8'h5A, 0, 0, 1, 0, 1, 3, 8, 0);
        wait_valid(1000, n, ok);
        check("postrst_valid", {31'd0, ok}, 32'd1);
        check("postrst_byte", {22'd0, frame_err, parity_err, rx_data}, 32'h05A);
        accept_byte("postrst");

        // Randomized frames against the frame-level model.
        mon_en = 1'b1;
        rand_ready = 1'b1;
        for (int i = 0; i < 25; i++) begin
            d    = 8'($urandom_range(0, 255));
            pen  = 1'($urandom_range(0, 1));
            podd = 1'($urandom_range(0, 1));
            s2   = 1'($urandom_range(0, 1));
            pbit = 1'($urandom_range(0, 1));
            st1  = ($urandom_range(0, 5) != 0);
            st2  = ($urandom_range(0, 5) != 0);
            div  = $urandom_range(0, 3);
            set_cfg(pen, podd, s2, 16'(div));
            exp_q.push_back(model(d, pen, podd, pbit, st1, s2, st2));
            send_frame(d, pen, pbit, st1, s2, st2, div, $urandom_range(3, 20), 1);
        end
        n = 0;
        while (exp_q.size() != 0 && n < 2000) begin
            cyc(1);
            n++;
        end
        check("rand_drain", exp_q.size(), 32'd0);
        rand_ready = 1'b0;
        mon_en = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #3_000_000;
        n_bad++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
